// File: rtl/game_ctrl.sv
// ---------------------------------------------------------------------------
// game_ctrl -- frame-rate Breakout sequencer.
//
// Sits beside `ball`. It drives ball's configuration (menu flag, level block
// map, reload/freeze reset) and watches ball's status (remaining blocks, lives)
// to score cleared blocks, advance levels and detect game over or win.
// Everything steps once per frame on frame_clk.
//
// Optional feature macro: GAME_HISCORE_EN. When it is defined, a high-score
// register tracks the best score seen since Reset. When it is not defined,
// hiscore is tied to zero.
//
// Ports:
//   frame_clk    in   1  frame clock, rising edge
//   Reset        in   1  asynchronous, active-high reset
//   keycode      in   8  current USB keycode (8'h2C = space)
//   Blocks       in  32  remaining-block map from ball
//   lives        in   2  remaining lives from ball
//   start_menu   out  1  high while in MENU
//   Block_Array  out 32  level block map for ball
//   ball_reset   out  1  holds ball in reload/freeze (everything except PLAY)
//   level        out  2  current level index
//   score        out 16  packed 4-digit BCD score
//   game_over    out  1  high in GAME_OVER
//   game_won     out  1  high in WIN
//   hiscore      out 16  packed BCD high score (zero unless GAME_HISCORE_EN)
// ---------------------------------------------------------------------------
module game_ctrl #(
    parameter int          NUM_LEVELS = 3,
    parameter logic [31:0] LEVEL0_MAP = 32'hFFFF_FFFF,
    parameter logic [31:0] LEVEL1_MAP = 32'h5AA5_5AA5,
    parameter logic [31:0] LEVEL2_MAP = 32'hFF81_81FF,
    parameter logic [31:0] LEVEL3_MAP = 32'hFFFF_0000,
    parameter logic [15:0] POINTS     = 16'h0010
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [7:0]  keycode,
    input  logic [31:0] Blocks,
    input  logic [1:0]  lives,
    output logic        start_menu,
    output logic [31:0] Block_Array,
    output logic        ball_reset,
    output logic [1:0]  level,
    output logic [15:0] score,
    output logic        game_over,
    output logic        game_won,
    output logic [15:0] hiscore
);

    typedef enum logic [2:0] {
        S_MENU,
        S_LOAD,
        S_PLAY,
        S_GAME_OVER,
        S_WIN
    } state_t;

    localparam logic [1:0] LAST_LEVEL = 2'(NUM_LEVELS - 1);
    localparam logic [7:0] KEY_SPACE  = 8'h2C;

    state_t      state, state_nxt;
    logic [1:0]  level_nxt;
    logic [31:0] prev;       // block map as of last PLAY frame
    logic [5:0]  pend;       // blocks cleared but not yet scored
    logic        sp_q;       // last frame's "space is down"

    logic        sp_now;
    logic        sp_edge;
    logic [5:0]  cleared;
    logic [6:0]  pend_sum;
    logic [5:0]  pend_nxt;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic [31:0] level_map(input logic [1:0] lvl);
        case (lvl)
            2'd0:    return LEVEL0_MAP;
            2'd1:    return LEVEL1_MAP;
            2'd2:    return LEVEL2_MAP;
            default: return LEVEL3_MAP;
        endcase
    endfunction

    // Per-digit BCD add with ripple carry. A carry out of the top digit
    // means the true sum passed 9999, so the result pins at 9999.
    function automatic logic [15:0] bcd_add_sat(input logic [15:0] a,
                                                 input logic [15:0] b);
        logic [15:0] sum;
        logic [4:0]  d;
        logic        c;
        sum = '0;
        c   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, c};
            if (d > 5'd9) begin
                sum[4*i +: 4] = 4'(d - 5'd10);
                c             = 1'b1;
            end else begin
                sum[4*i +: 4] = d[3:0];
                c             = 1'b0;
            end
        end
        return c ? 16'h9999 : sum;
    endfunction

    // ------------------------------------------------------------------
    // Space edge: a held key yields one edge, on its first frame.
    // ------------------------------------------------------------------
    assign sp_now  = (keycode == KEY_SPACE);
    assign sp_edge = sp_now && !sp_q;

    // ------------------------------------------------------------------
    // Cleared-block count: bits that were present last PLAY frame and are
    // gone now. Blocks reappearing (1 where prev had 0) do not count.
    // ------------------------------------------------------------------
    always_comb begin
        cleared = '0;
        if (state == S_PLAY) begin
            for (int i = 0; i < 32; i++) begin
                cleared = cleared + 6'(prev[i] & ~Blocks[i]);
            end
        end
    end

    // pend gains this frame's clears and loses one per scored frame;
    // 7-bit intermediate so the saturation at 63 can be seen.
    always_comb begin
        pend_sum = {1'b0, pend} + {1'b0, cleared} - {6'd0, (pend != 6'd0)};
        pend_nxt = (pend_sum > 7'd63) ? 6'd63 : pend_sum[5:0];
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        level_nxt = level;
        case (state)
            S_MENU: begin
                if (sp_edge) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                state_nxt = S_PLAY;
            end
            S_PLAY: begin
                // Losing the last life wins over finishing the level.
                if (lives == 2'd0) begin
                    state_nxt = S_GAME_OVER;
                end else if (Blocks == 32'd0 && pend == 6'd0) begin
                    if (level == LAST_LEVEL) begin
                        state_nxt = S_WIN;
                    end else begin
                        level_nxt = level + 2'd1;
                        state_nxt = S_LOAD;
                    end
                end
            end
            S_GAME_OVER, S_WIN: begin
                if (sp_edge) state_nxt = S_MENU;
            end
            default: begin
                state_nxt = S_MENU;
            end
        endcase
        if (state_nxt == S_MENU) level_nxt = 2'd0;
    end

    // ------------------------------------------------------------------
    // State, registered outputs and scoring. Flag outputs are registered
    // from the next state so they line up with the state they describe.
    // ------------------------------------------------------------------
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state       <= S_MENU;
            level       <= 2'd0;
            sp_q        <= 1'b0;
            start_menu  <= 1'b1;
            ball_reset  <= 1'b1;
            game_over   <= 1'b0;
            game_won    <= 1'b0;
            Block_Array <= LEVEL0_MAP;
            prev        <= '0;
            pend        <= '0;
            score       <= '0;
        end else begin
            state      <= state_nxt;
            level      <= level_nxt;
            sp_q       <= sp_now;
            start_menu <= (state_nxt == S_MENU);
            ball_reset <= (state_nxt != S_PLAY);
            game_over  <= (state_nxt == S_GAME_OVER);
            game_won   <= (state_nxt == S_WIN);

            // Entering LOAD publishes the new map; prev starts from the same
            // map so the first PLAY frame only counts real clears.
            if (state_nxt == S_LOAD) begin
                Block_Array <= level_map(level_nxt);
                prev        <= level_map(level_nxt);
            end else if (state == S_PLAY) begin
                prev <= Blocks;
            end

            // pend keeps draining into score outside PLAY; only MENU wipes it.
            if (state_nxt == S_MENU) begin
                pend  <= '0;
                score <= '0;
            end else begin
                pend <= pend_nxt;
                if (pend != 6'd0) score <= bcd_add_sat(score, POINTS);
            end
        end
    end

    // ------------------------------------------------------------------
    // High score. Valid packed BCD orders the same as unsigned binary, so a
    // plain magnitude compare is enough. Lags score by one frame.
    // ------------------------------------------------------------------
`ifdef GAME_HISCORE_EN
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            hiscore <= '0;
        end else if (score > hiscore) begin
            hiscore <= score;
        end
    end
`else
    assign hiscore = 16'h0000;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Testbench for game_ctrl. Two instances share stimulus: u_dut with default
// parameters and u_sat with POINTS=0005 so the 9995 -> 9999 saturation case
// is reachable. A frame-level reference model pushes expected outputs per
// frame; they are popped and compared after the DUT's clock edge.
module tb_game_ctrl;

    logic        frame_clk = 1'b0;
    logic        Reset;
    logic [7:0]  keycode;
    logic [31:0] Blocks;
    logic [1:0]  lives;

    logic        start_menu, ball_reset, game_over, game_won;
    logic [31:0] Block_Array;
    logic [1:0]  level;
    logic [15:0] score, hiscore;

    logic        b_start_menu, b_ball_reset, b_game_over, b_game_won;
    logic [31:0] b_Block_Array;
    logic [1:0]  b_level;
    logic [15:0] b_score, b_hiscore;

    always #5 frame_clk = ~frame_clk;

    game_ctrl u_dut (
        .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
        .Blocks(Blocks), .lives(lives), .start_menu(start_menu),
        .Block_Array(Block_Array), .ball_reset(ball_reset), .level(level),
        .score(score), .game_over(game_over), .game_won(game_won),
        .hiscore(hiscore)
    );

    game_ctrl #(.POINTS(16'h0005)) u_sat (
        .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
        .Blocks(Blocks), .lives(lives), .start_menu(b_start_menu),
        .Block_Array(b_Block_Array), .ball_reset(b_ball_reset), .level(b_level),
        .score(b_score), .game_over(b_game_over), .game_won(b_game_won),
        .hiscore(b_hiscore)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic        sm, br, go, gw;
        logic [1:0]  lvl;
        logic [31:0] ba;
        logic [15:0] sc_a, sc_b, hi_a, hi_b;
    } exp_t;

    exp_t sb_q[$];

    localparam int NL = 3;
    // states: 0 MENU, 1 LOAD, 2 PLAY, 3 GAME_OVER, 4 WIN
    int          m_st, m_lvl, m_pend, m_pts, m_hi_a, m_hi_b;
    bit          m_sp;
    logic [31:0] m_prev, m_ba;

    function automatic logic [31:0] map_of(input int l);
        logic [31:0] maps [4];
        maps = '{32'hFFFF_FFFF, 32'h5AA5_5AA5, 32'hFF81_81FF, 32'hFFFF_0000};
        return maps[l];
    endfunction

    // score value after n scored frames: each step adds p and pins at 9999
    function automatic int sc_int(input int n, input int p);
        int v;
        v = n * p;
        return (v > 9999) ? 9999 : v;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_st = 0; m_lvl = 0; m_pend = 0; m_pts = 0;
        m_hi_a = 0; m_hi_b = 0; m_sp = 0;
        m_prev = '0; m_ba = 32'hFFFF_FFFF;
    endtask

    task automatic model_step(input logic [7:0] kc, input logic [31:0] blk, input logic [1:0] lv);
        bit   sp_now, sp_edge;
        int   clr, p0, nst;
        exp_t e;
        sp_now  = (kc == 8'h2C);
        sp_edge = sp_now && !m_sp;
        m_sp    = sp_now;
        clr = 0;
        if (m_st == 2)
            for (int i = 0; i < 32; i++) if (m_prev[i] && !blk[i]) clr++;
        p0  = m_pend;
        nst = m_st;
`ifdef GAME_HISCORE_EN
        if (sc_int(m_pts, 10) > m_hi_a) m_hi_a = sc_int(m_pts, 10);
        if (sc_int(m_pts, 5)  > m_hi_b) m_hi_b = sc_int(m_pts, 5);
`endif
        case (m_st)
            0: if (sp_edge) nst = 1;
            1: nst = 2;
            2: begin
                if (lv == 2'd0) nst = 3;
                else if (blk == 32'd0 && p0 == 0) begin
                    if (m_lvl == NL - 1) nst = 4;
                    else begin m_lvl = m_lvl + 1; nst = 1; end
                end
            end
            default: if (sp_edge) nst = 0;
        endcase
        if (nst == 0) begin
            m_lvl = 0; m_pend = 0; m_pts = 0;
        end else begin
            if (p0 != 0) m_pts++;
            m_pend = p0 + clr - ((p0 != 0) ? 1 : 0);
            if (m_pend > 63) m_pend = 63;
        end
        if (nst == 1) begin
            m_ba = map_of(m_lvl); m_prev = m_ba;
        end else if (m_st == 2) begin
            m_prev = blk;
        end
        m_st = nst;
        e.sm   = (nst == 0);
        e.br   = (nst != 2);
        e.go   = (nst == 3);
        e.gw   = (nst == 4);
        e.lvl  = 2'(m_lvl);
        e.ba   = m_ba;
        e.sc_a = to_bcd(sc_int(m_pts, 10));
        e.sc_b = to_bcd(sc_int(m_pts, 5));
        e.hi_a = to_bcd(m_hi_a);
        e.hi_b = to_bcd(m_hi_b);
        sb_q.push_back(e);
    endtask

    // Drive one frame at the falling edge, check after the rising edge.
    task automatic frame(input logic [7:0] kc, input logic [31:0] blk, input logic [1:0] lv);
        exp_t e;
        keycode = kc; Blocks = blk; lives = lv;
        model_step(kc, blk, lv);
        @(posedge frame_clk);
        #1;
        if (sb_q.size() == 0) begin
            n_miss++;
            $display("FAIL scoreboard underflow");
        end else begin
            e = sb_q.pop_front();
            chk("start_menu",  32'(start_menu),  32'(e.sm));
            chk("ball_reset",  32'(ball_reset),  32'(e.br));
            chk("game_over",   32'(game_over),   32'(e.go));
            chk("game_won",    32'(game_won),    32'(e.gw));
            chk("level",       32'(level),       32'(e.lvl));
            chk("Block_Array", Block_Array,      e.ba);
            chk("score",       32'(score),       32'(e.sc_a));
            chk("hiscore",     32'(hiscore),     32'(e.hi_a));
            chk("b_ball_reset",32'(b_ball_reset),32'(e.br));
            chk("b_state",     32'({b_start_menu, b_game_over, b_game_won}), 32'({e.sm, e.go, e.gw}));
            chk("b_level_map", b_Block_Array ^ 32'(b_level), e.ba ^ 32'(e.lvl));
            chk("b_score",     32'(b_score),     32'(e.sc_b));
            chk("b_hiscore",   32'(b_hiscore),   32'(e.hi_b));
        end
        @(negedge frame_clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_start_menu"}, 32'(start_menu), 32'd1);
        chk({tag, "_ball_reset"}, 32'(ball_reset), 32'd1);
        chk({tag, "_game_over"},  32'(game_over),  32'd0);
        chk({tag, "_game_won"},   32'(game_won),   32'd0);
        chk({tag, "_level"},      32'(level),      32'd0);
        chk({tag, "_Block_Array"},Block_Array,     32'hFFFF_FFFF);
        chk({tag, "_score"},      32'(score),      32'd0);
        chk({tag, "_hiscore"},    32'(hiscore),    32'd0);
        chk({tag, "_b_score"},    32'(b_score),    32'd0);
        chk({tag, "_b_hiscore"},  32'(b_hiscore),  32'd0);
    endtask

    initial begin
        Reset = 1'b0; keycode = 8'h00; Blocks = 32'hFFFF_FFFF; lives = 2'd3;
        #1 Reset = 1'b1;
        #1 check_reset_vals("rst0");
        model_reset();
        @(negedge frame_clk);
        Reset = 1'b0;

        // Held space: one LOAD frame, then PLAY.
        for (int i = 0; i < 5; i++) frame(8'h2C, 32'hFFFF_FFFF, 2'd3);
        for (int i = 0; i < 2; i++) frame(8'h00, 32'hFFFF_FFFF, 2'd3);

        // Two blocks in one frame -> 0010 then 0020.
        for (int i = 0; i < 4; i++) frame(8'h00, 32'hFFFF_FFFC, 2'd3);
        // Ten more -> 0120.
        for (int i = 0; i < 12; i++) frame(8'h00, 32'hFFFF_F000, 2'd3);

        // Asynchronous reset mid-frame during PLAY.
        #2 Reset = 1'b1;
        #1 check_reset_vals("rst_play");
        model_reset();
        @(negedge frame_clk);
        Reset = 1'b0;

        // Game 2: clear every level, ending in WIN.
        frame(8'h2C, 32'hFFFF_FFFF, 2'd3);
        frame(8'h00, 32'hFFFF_FFFF, 2'd3);
        frame(8'h00, 32'h0000_0000, 2'd3);          // immediate advance, pend=32
        for (int i = 0; i < 4; i++) frame(8'h00, 32'h5AA5_5AA5, 2'd3);
        for (int i = 0; i < 120 && m_lvl == 1; i++) frame(8'h00, 32'h0, 2'd3);
        for (int i = 0; i < 3; i++) frame(8'h00, 32'hFF81_81FF, 2'd3);
        for (int i = 0; i < 120 && m_st != 4; i++) frame(8'h00, 32'h0, 2'd3);
        for (int i = 0; i < 3; i++) frame(8'h00, 32'h0, 2'd3);
        frame(8'h2C, 32'h0, 2'd3);                  // WIN -> MENU
        frame(8'h00, 32'hFFFF_FFFF, 2'd3);

        // Game 3: lives hit zero together with Blocks==0 -> GAME_OVER.
        frame(8'h2C, 32'hFFFF_FFFF, 2'd3);
        frame(8'h00, 32'hFFFF_FFFF, 2'd3);
        for (int i = 0; i < 20; i++) frame(8'h00, 32'hFFFF_0000, 2'd3);
        frame(8'h00, 32'h0, 2'd0);
        for (int i = 0; i < 20; i++) frame(8'h00, 32'h0, 2'd0);
        frame(8'h2C, 32'h0, 2'd0);                  // GAME_OVER -> MENU
        for (int i = 0; i < 2; i++) frame(8'h00, 32'hFFFF_FFFF, 2'd3);

        // Game 4: toggle one block to walk u_sat to 9995, then one more.
        frame(8'h2C, 32'hFFFF_FFFF, 2'd3);
        frame(8'h00, 32'hFFFF_FFFF, 2'd3);
        for (int i = 0; i < 2500 && m_pts < 1999; i++) begin
            frame(8'h00, 32'hFFFF_FFFE, 2'd3);
            frame(8'h00, 32'hFFFF_FFFF, 2'd3);
        end
        chk("b_score_9995", 32'(b_score), 32'h9995);
        frame(8'h00, 32'hFFFF_FFFE, 2'd3);
        frame(8'h00, 32'hFFFF_FFFF, 2'd3);
        chk("b_score_sat", 32'(b_score), 32'h9999);
        for (int i = 0; i < 4; i++) begin
            frame(8'h00, 32'hFFFF_FFFE, 2'd3);
            frame(8'h00, 32'hFFFF_FFFF, 2'd3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Frame-rate game sequencer for Breakout. It sits beside `ball` and drives that block's configuration inputs: `start_menu`, the level block map, and a reload/freeze reset. It consumes `ball`'s status outputs (`Blocks`, `lives`) to score cleared blocks, advance levels, and detect game over or win. All logic runs once per frame on `frame_clk`.

## Interface
Parameters:
- `NUM_LEVELS`, default 3 — number of levels; legal range 1..4.
- `LEVEL0_MAP`, default 32'hFFFF_FFFF — block map for level 0. Bit i is the block at column i%8, row i>>3.
- `LEVEL1_MAP`, default 32'h5AA5_5AA5 — block map for level 1.
- `LEVEL2_MAP`, default 32'hFF81_81FF — block map for level 2.
- `LEVEL3_MAP`, default 32'hFFFF_0000 — block map for level 3.
- `POINTS`, default 16'h0010 — packed 4-digit BCD points added per cleared block.

Ports:
- `frame_clk`  in  1  frame clock; all state updates on its rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `keycode`  in  8  current USB keycode; 8'h2C is space.
- `Blocks`  in  32  remaining-block map from `ball`.
- `lives`  in  2  remaining lives from `ball`.
- `start_menu`  out  1  high while in MENU.
- `Block_Array`  out  32  level map for `ball`; top level zero-extends it to 33 bits.
- `ball_reset`  out  1  OR'd with `Reset` at top level into `ball.Reset`.
- `level`  out  2  current level index.
- `score`  out  16  packed 4-digit BCD score.
- `game_over`  out  1  high in GAME_OVER.
- `game_won`  out  1  high in WIN.
- `hiscore`  out  16  packed BCD high score (see Configuration).

## Operation
- States:
  - MENU: clears `score` and `level` on entry.
    - `start_menu`=1, `ball_reset`=1.
    - Space edge → LOAD.
  - LOAD: one frame.
    - `ball_reset`=1, `Block_Array`=map[`level`], `prev`<=map[`level`].
    - → PLAY.
  - PLAY: `ball_reset`=0.
    - `lives`==0 → GAME_OVER.
    - Else if `Blocks`==0 and `pend`==0: if `level`==NUM_LEVELS-1 → WIN; else `level`+1 → LOAD.
  - GAME_OVER and WIN: `ball_reset`=1.
    - `game_over` or `game_won`=1 respectively.
    - Space edge → MENU.
- Space edge: asserted when (`keycode`==8'h2C) && !`sp_q`, where `sp_q` holds last frame's (`keycode`==8'h2C). A held key produces exactly one edge.
- Block scoring (PLAY only):
  - Cleared count is popcount(`prev` & ~`Blocks`).
  - Bits that become set are ignored.
  - `prev`<=`Blocks` every PLAY frame.
- Pending counter `pend`, 6 bits:
  - Each frame, `pend` <= sat63(`pend` + cleared − (`pend`!=0)).
  - While `pend`!=0, `score` += `POINTS` as a per-digit BCD add with carry.
  - Score saturates at 16'h9999; it never wraps.
- `pend` keeps draining in GAME_OVER and WIN. It is zeroed on entry to MENU.
- Lives are restored to 3 by `ball` at every LOAD. This is intended behaviour: lives reset per level.
- Priority within PLAY: `lives`==0 beats level clear.
- `Block_Array` holds its value outside LOAD.

## Timing
- All outputs are registered.
- Reset values:
  - state MENU, `start_menu`=1, `ball_reset`=1.
  - `Block_Array`=LEVEL0_MAP, `level`=0.
  - `score`=0, `pend`=0, `prev`=0, `sp_q`=0.
  - `game_over`=0, `game_won`=0, `hiscore`=0.
- Space edge in MENU at frame n:
  - LOAD at n+1: `ball_reset`=1 and new `Block_Array` visible.
  - PLAY at n+2: `ball_reset` falls.
- Block cleared by `ball` at frame n: `pend` increments at n+1, and `score` rises by `POINTS` at n+2.
- k blocks cleared in one frame: score rises on k consecutive frames.
- Level clear: takes effect one frame after `pend` reaches 0 with `Blocks`==0.
- Reset asserted mid-operation: asynchronous return to reset values. `hiscore` is also cleared.

## Configuration
- `GAME_HISCORE_EN` defined:
  - `hiscore` <= `score` on any frame where `score` > `hiscore`. Packed-BCD compare is done as an unsigned compare.
  - `hiscore` survives MENU and is cleared only by `Reset`.
- `GAME_HISCORE_EN` undefined: `hiscore` is tied to 16'h0000 and no register is inferred.

## Test plan
- Reset, then hold `keycode`=8'h2C for 5 frames → exactly one LOAD frame with `Block_Array`=FFFF_FFFF, then PLAY, `start_menu`=0.
- In PLAY, change `Blocks` from FFFF_FFFF to FFFF_FFFC in one frame → `pend`=2, then `score` goes 0010 then 0020 on consecutive frames.
- With `score`=9995 and one block cleared → `score`=9999 (saturated).
- Drive `Blocks`=0 on level 0 with NUM_LEVELS=3 → `pend` drains, LOAD with `level`=1 and `Block_Array`=5AA5_5AA5. On level 2, the same stimulus → WIN, `game_won`=1, `ball_reset`=1.
- Drive `lives`=0 in the same frame as `Blocks`=0 → GAME_OVER, not a level advance. A space edge then → MENU with `score`=0. With `GAME_HISCORE_EN`, `hiscore` keeps the prior score.
- Assert `Reset` during PLAY with `score`=0120 → all outputs return to reset values immediately, `hiscore`=0.
